// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaler and period counter, double-buffered period/duty.
// Optional build macro PWM_CENTER_ALIGN_EN selects up/down (center-aligned) counting.
module pwm_multi #(
  parameter int CH      = 4,
  parameter int CNT_W   = 16,
  parameter int PRESC_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [PRESC_W-1:0]    prescale,
  input  logic [CNT_W-1:0]      period,
  input  logic [CH*CNT_W-1:0]   duty,
  input  logic                  load,
  output logic [CH-1:0]         pwm_out,
  output logic                  cycle_start,
  output logic                  load_ack
);

  logic [PRESC_W-1:0]  psc_r;
  logic [PRESC_W-1:0]  prescale_act_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    period_act_r;
  logic [CH*CNT_W-1:0] duty_act_r;
  logic                load_pending_r;
  logic [CNT_W-1:0]    cnt_nxt_s;
  logic                tick_s;
  logic                wrap_s;
  logic                apply_s;
  logic [CH-1:0]       cmp_s;
`ifdef PWM_CENTER_ALIGN_EN
  logic                dir_up_r;
  logic                dir_up_nxt_s;
`endif

  // Prescaler terminal count and shadow-transfer qualification
  always_comb begin
    tick_s  = (psc_r == prescale_act_r);
    apply_s = wrap_s && (load_pending_r || load);
  end

  // Next counter value and wrap detection (cycle boundary)
  always_comb begin
    cnt_nxt_s = cnt_r;
    wrap_s    = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
    dir_up_nxt_s = dir_up_r;
    if (tick_s) begin
      if (dir_up_r) begin
        if (cnt_r == period_act_r) begin
          // period 0 holds 0 for two ticks; period 1 has no interior down step
          if (period_act_r == {CNT_W{1'b0}}) begin
            dir_up_nxt_s = 1'b0;
            cnt_nxt_s    = {CNT_W{1'b0}};
          end else if (period_act_r == CNT_W'(1)) begin
            wrap_s    = 1'b1;
            cnt_nxt_s = {CNT_W{1'b0}};
          end else begin
            dir_up_nxt_s = 1'b0;
            cnt_nxt_s    = cnt_r - CNT_W'(1);
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end else begin
        if (cnt_r <= CNT_W'(1)) begin
          wrap_s       = 1'b1;
          dir_up_nxt_s = 1'b1;
          cnt_nxt_s    = {CNT_W{1'b0}};
        end else begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
`else
    if (tick_s) begin
      if (cnt_r == period_act_r) begin
        wrap_s    = 1'b1;
        cnt_nxt_s = {CNT_W{1'b0}};
      end else begin
        cnt_nxt_s = cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
`endif
  end

  // Per-channel compare against the active duty values
  always_comb begin
    cmp_s = {CH{1'b0}};
    for (int i = 0; i < CH; i++) begin
      cmp_s[i] = (cnt_r < duty_act_r[i*CNT_W +: CNT_W]);
    end
  end

  // Counter state, shadow registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_r          <= {PRESC_W{1'b0}};
      cnt_r          <= {CNT_W{1'b0}};
      prescale_act_r <= {PRESC_W{1'b0}};
      period_act_r   <= {CNT_W{1'b0}};
      duty_act_r     <= {(CH*CNT_W){1'b0}};
      load_pending_r <= 1'b0;
      pwm_out        <= {CH{1'b0}};
      cycle_start    <= 1'b0;
      load_ack       <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      dir_up_r       <= 1'b1;
`endif
    end else if (!en) begin
      // Idle: track inputs so enabling starts straight away with current values
      psc_r          <= {PRESC_W{1'b0}};
      cnt_r          <= {CNT_W{1'b0}};
      prescale_act_r <= prescale;
      period_act_r   <= period;
      duty_act_r     <= duty;
      load_pending_r <= 1'b0;
      pwm_out        <= {CH{1'b0}};
      cycle_start    <= 1'b0;
      load_ack       <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      dir_up_r       <= 1'b1;
`endif
    end else begin
      psc_r       <= tick_s ? {PRESC_W{1'b0}} : psc_r + PRESC_W'(1);
      cnt_r       <= cnt_nxt_s;
      pwm_out     <= cmp_s;
      cycle_start <= wrap_s;
      load_ack    <= apply_s;
`ifdef PWM_CENTER_ALIGN_EN
      dir_up_r    <= dir_up_nxt_s;
`endif
      if (apply_s) begin
        prescale_act_r <= prescale;
        period_act_r   <= period;
        duty_act_r     <= duty;
        load_pending_r <= 1'b0;
      end else if (load) begin
        load_pending_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi (edge-aligned build), with a position-based reference model.
module tb_pwm_multi;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [7:0]  prescale;
  logic [15:0] period;
  logic [63:0] duty;
  logic [3:0]  pwm_out;
  logic        cycle_start;
  logic        load_ack;

  int checks   = 0;
  int failures = 0;

  // model: position within the current PWM cycle, measured in clks
  int       m_pos, m_presc, m_per;
  int       m_duty [4];
  bit       m_pend;
  logic [3:0] e_pwm;
  logic     e_cs, e_ack;

  pwm_multi #(.CH(4), .CNT_W(16), .PRESC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .prescale(prescale), .period(period),
    .duty(duty), .load(load), .pwm_out(pwm_out), .cycle_start(cycle_start),
    .load_ack(load_ack)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pos = 0; m_presc = 0; m_per = 0; m_pend = 1'b0;
    for (int i = 0; i < 4; i++) m_duty[i] = 0;
    e_pwm = 4'b0; e_cs = 1'b0; e_ack = 1'b0;
  endtask

  task automatic take_inputs();
    m_presc = int'(prescale);
    m_per   = int'(period);
    for (int i = 0; i < 4; i++) m_duty[i] = int'(duty[i*16 +: 16]);
  endtask

  // advance the model with the inputs present at this edge, then clock the DUT
  task automatic step();
    int len, cnt;
    bit wrap, doload;
    if (!rst_n) begin
      model_reset();
    end else if (!en) begin
      m_pos = 0; m_pend = 1'b0; e_pwm = 4'b0; e_cs = 1'b0; e_ack = 1'b0;
      take_inputs();
    end else begin
      len = (m_presc + 1) * (m_per + 1);
      cnt = m_pos / (m_presc + 1);
      for (int i = 0; i < 4; i++) e_pwm[i] = (cnt < m_duty[i]);
      wrap   = (m_pos == len - 1);
      doload = wrap && (m_pend || load);
      e_cs   = wrap;
      e_ack  = doload;
      if (wrap) begin
        m_pos = 0;
        if (doload) begin take_inputs(); m_pend = 1'b0; end
      end else begin
        m_pos++;
        if (load) m_pend = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; load = 1'b0; prescale = 8'd0; period = 16'd0; duty = 64'd0;
    repeat (3) step();
    checks++;
    if (pwm_out !== 4'b0 || cycle_start !== 1'b0 || load_ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_state pwm=%b cs=%b ack=%b expected 0000/0/0", pwm_out, cycle_start, load_ack);
    end
    rst_n = 1'b1;
    prescale = 8'd0; period = 16'd3; duty = {4{16'd9}};
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (pwm_out !== 4'b0 || cycle_start !== 1'b0) begin
        failures++;
        $display("FAIL idle_en_low pwm=%b cs=%b expected 0000/0", pwm_out, cycle_start);
      end
    end
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (pwm_out !== 4'b1111) begin
        failures++;
        $display("FAIL full_duty pwm=%b expected 1111", pwm_out);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pwm_out !== 4'b0 || cycle_start !== 1'b0 || load_ack !== 1'b0) begin
      failures++;
      $display("FAIL async_reset pwm=%b cs=%b ack=%b expected 0000/0/0", pwm_out, cycle_start, load_ack);
    end
    en = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_basic_ratio();
    int hi [4];
    int cs_n = 0;
    int want [4] = '{0, 6, 10, 20};
    for (int i = 0; i < 4; i++) hi[i] = 0;
    en = 1'b0; prescale = 8'd0; period = 16'd9;
    duty = {16'd12, 16'd5, 16'd3, 16'd0};
    step();
    en = 1'b1;
    for (int k = 0; k < 25; k++) begin
      step();
      checks++;
      if (pwm_out !== e_pwm || cycle_start !== e_cs || load_ack !== e_ack) begin
        failures++;
        $display("FAIL basic_model k=%0d pwm=%b/%b cs=%b/%b ack=%b/%b (dut/model)",
                 k, pwm_out, e_pwm, cycle_start, e_cs, load_ack, e_ack);
      end
      if (k >= 5) begin
        for (int i = 0; i < 4; i++) hi[i] += int'(pwm_out[i]);
        cs_n += int'(cycle_start);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (hi[i] !== want[i]) begin
        failures++;
        $display("FAIL basic_ratio ch%0d high=%0d expected %0d", i, hi[i], want[i]);
      end
    end
    checks++;
    if (cs_n !== 2) begin
      failures++;
      $display("FAIL basic_cycle_start count=%0d expected 2", cs_n);
    end
  endtask

  task automatic test_prescaler();
    int hi0 = 0;
    int cs_n = 0;
    en = 1'b0; prescale = 8'd3; period = 16'd4; duty = {48'd0, 16'd2};
    step();
    en = 1'b1;
    for (int k = 0; k < 45; k++) begin
      step();
      checks++;
      if (pwm_out !== e_pwm || cycle_start !== e_cs) begin
        failures++;
        $display("FAIL presc_model k=%0d pwm=%b/%b cs=%b/%b (dut/model)", k, pwm_out, e_pwm, cycle_start, e_cs);
      end
      if (k >= 5) begin
        hi0  += int'(pwm_out[0]);
        cs_n += int'(cycle_start);
      end
    end
    checks++;
    if (hi0 !== 16 || cs_n !== 2) begin
      failures++;
      $display("FAIL prescaler high=%0d cs=%0d expected 16/2", hi0, cs_n);
    end
  endtask

  task automatic test_glitch_free();
    bit found = 1'b0;
    int hi_cur = 0, hi_nxt = 0, acks = 0;
    logic ack10 = 1'b0;
    en = 1'b0; prescale = 8'd0; period = 16'd9; duty = {4{16'd5}};
    step();
    en = 1'b1;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      if (cycle_start) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL glitch_wait_cs timeout expected a cycle_start within 40 clks");
    end
    for (int s = 1; s <= 20; s++) begin
      if (s == 4) begin duty = {4{16'd2}}; load = 1'b1; end
      step();
      load = 1'b0;
      if (s <= 10) hi_cur += int'(pwm_out[0]); else hi_nxt += int'(pwm_out[0]);
      acks += int'(load_ack);
      if (s == 10) ack10 = load_ack;
    end
    checks++;
    if (hi_cur !== 5 || hi_nxt !== 2) begin
      failures++;
      $display("FAIL glitch_pulse cur=%0d next=%0d expected 5/2", hi_cur, hi_nxt);
    end
    checks++;
    if (acks !== 1 || ack10 !== 1'b1) begin
      failures++;
      $display("FAIL glitch_load_ack count=%0d at_wrap=%b expected 1/1", acks, ack10);
    end
  endtask

  task automatic test_boundary_load();
    bit found = 1'b0;
    int hi_a = 0, hi_b = 0, hi_c = 0, acks = 0;
    logic ack10 = 1'b0;
    en = 1'b0; prescale = 8'd0; period = 16'd9; duty = {4{16'd5}};
    step();
    en = 1'b1;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      if (cycle_start) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL boundary_wait_cs timeout expected a cycle_start within 40 clks");
    end
    for (int s = 1; s <= 40; s++) begin
      if (s == 3)  duty = {4{16'd1}};
      if (s == 10) begin duty = {4{16'd7}}; load = 1'b1; end
      if (s == 12) duty = {4{16'd3}};
      step();
      load = 1'b0;
      if (s <= 10) hi_a += int'(pwm_out[1]);
      else if (s <= 20) hi_b += int'(pwm_out[1]);
      else hi_c += int'(pwm_out[1]);
      acks += int'(load_ack);
      if (s == 10) ack10 = load_ack;
    end
    checks++;
    if (hi_a !== 5 || hi_b !== 7 || hi_c !== 14) begin
      failures++;
      $display("FAIL boundary_load high=%0d/%0d/%0d expected 5/7/14", hi_a, hi_b, hi_c);
    end
    checks++;
    if (acks !== 1 || ack10 !== 1'b1) begin
      failures++;
      $display("FAIL boundary_ack count=%0d at_wrap=%b expected 1/1", acks, ack10);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      en = 1'b0;
      prescale = 8'($urandom_range(3, 0));
      period   = 16'($urandom_range(12, 0));
      for (int i = 0; i < 4; i++) duty[i*16 +: 16] = 16'($urandom_range(14, 0));
      step();
      en = 1'b1;
      for (int k = 0; k < 90; k++) begin
        if ($urandom_range(7, 0) == 0) begin
          prescale = 8'($urandom_range(3, 0));
          period   = 16'($urandom_range(12, 0));
          for (int i = 0; i < 4; i++) duty[i*16 +: 16] = 16'($urandom_range(14, 0));
        end
        load = ($urandom_range(15, 0) == 0);
        en   = ($urandom_range(63, 0) != 0);
        step();
        load = 1'b0;
        en   = 1'b1;
        checks++;
        if (pwm_out !== e_pwm || cycle_start !== e_cs || load_ack !== e_ack) begin
          failures++;
          $display("FAIL random it=%0d k=%0d pwm=%b/%b cs=%b/%b ack=%b/%b (dut/model)",
                   it, k, pwm_out, e_pwm, cycle_start, e_cs, load_ack, e_ack);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_ratio();
    test_prescaler();
    test_glitch_free();
    test_boundary_load();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Multi-channel PWM generator with a shared prescaler, a shared period counter, and one compare output per channel.
- Period and duty are loaded into double-buffered shadow registers. New values take effect only at a period boundary, so output pulses are never glitched.
- Sits between the control/register logic and the pins. It replaces the single-channel fixed-50-cycle PWM counter.

Parameters:
- CH, 4, number of PWM channels (1..16).
- CNT_W, 16, width of the period counter, period and duty values.
- PRESC_W, 8, width of the prescaler reload value.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  block enable; low holds the block idle.
- prescale  in  PRESC_W  counter advances once every prescale+1 clk cycles.
- period  in  CNT_W  counter runs 0..period inclusive, giving period+1 ticks per cycle.
- duty  in  CH*CNT_W  per-channel compare value; channel i uses bits [i*CNT_W +: CNT_W].
- load  in  1  single-cycle request to transfer prescale/period/duty into the active registers.
- pwm_out  out  CH  PWM outputs, registered.
- cycle_start  out  1  one-clk pulse when the counter wraps to 0.
- load_ack  out  1  one-clk pulse on the cycle the active registers are updated.

Behaviour:
- Reset (rst_n low, asynchronous):
  - prescaler count, period counter, active regs and load_pending all go to 0.
  - pwm_out = 0, cycle_start = 0, load_ack = 0.
- en low:
  - Prescaler and counter are cleared to 0; pwm_out = 0; cycle_start = 0; load_pending is cleared.
  - Active regs copy the inputs every clk, so enabling starts immediately with current values.
  - load_ack stays 0 while en is low.
- Prescaler:
  - psc counts 0..prescale_act.
  - tick is asserted when psc == prescale_act, and psc then reloads to 0.
  - prescale = 0 gives a tick on every clk.
- Counter:
  - Advances on tick.
  - When cnt == period_act on a tick, cnt goes to 0 (wrap).
  - cycle_start is registered and asserts the clk after the wrap tick.
  - period_act = 0 means a 1-tick period.
- Compare, per channel i:
  - pwm_out[i] <= (cnt < duty_act[i]), registered, so the output lags cnt by 1 clk.
  - duty = 0 gives constant low.
  - duty > period_act gives constant high (100%).
  - Comparison is unsigned and CNT_W wide; no overflow is possible.
- Shadow load:
  - load high sets load_pending.
  - On the next wrap tick with load_pending set, all active regs update together, load_pending clears, and load_ack pulses on the following clk.
  - load on the same clk as a wrap tick takes effect at that wrap.
  - Repeated load while pending is harmless; the values sampled at the wrap clk are used.
- Mid-period changes to the inputs without load have no effect.
- Reset or en low mid-period aborts the cycle immediately; there is no completion of the current pulse.

Optional Feature:
- PWM_CENTER_ALIGN_EN:
  - When defined, the counter counts up 0..period_act and then down to 0. Direction flips at the period_act and 0 endpoints, and each endpoint value is held for exactly one tick.
  - The full cycle is 2*period_act ticks (minimum 2 ticks when period_act = 0; the counter stays at 0).
  - Compare rule is unchanged, so pulses are symmetric about count 0.
  - cycle_start and shadow updates occur only at the 0 endpoint, when starting an up count.
- When not defined: edge-aligned up-counting only, and no direction register is synthesised.

Test Plan:
- Reset/idle: rst_n low mid-run with pwm_out=4'b1111 → all outputs 0 in the same cycle, with no clk edge needed; en=0 → outputs stay 0.
- Basic ratio: CH=4, prescale=0, period=9, duty={0,3,5,12}, en=1 → over each 10-clk cycle, ch0 is 0 high clks, ch1 is 3, ch2 is 5, and ch3 is constant high; cycle_start pulses every 10 clks.
- Prescaler: prescale=3, period=4, duty ch0=2 → period of 20 clks, ch0 high for 8 clks.
- Glitch-free update: running period=9/duty=5, then change to duty=2 with a load pulse at mid-cycle → the current pulse stays 5 ticks; the next cycle is 2 ticks; load_ack pulses once, 1 clk after the wrap.
- Boundary load: load asserted on the exact wrap-tick clk → new values apply to the immediately starting cycle; a change without load is never applied.
- PWM_CENTER_ALIGN_EN defined: period=4, duty=2 → 8-tick cycle, pwm high for ticks at cnt 0,1 on both up and down slopes; cycle_start only at the 0 upward turn.
